// File: rtl/ysyx_24080006_commit.sv
// Commit/trap sequencer between the writeback unit and the CSR file.
// Retires one instruction per handshake and drives the CSR access for it.
// An ecall or mret additionally raises a held redirect to the fetch unit,
// and younger pipeline stages are flushed until the fetch unit accepts it.

package ysyx_24080006_commit_pkg;

    typedef struct packed {
        logic       csr_enable;
        logic [1:0] csr_op;
    } csr_set_t;

    typedef enum logic [2:0] {
        MSTATUS   = 3'd0,
        MTVEC     = 3'd1,
        MEPC      = 3'd2,
        MCAUSE    = 3'd3,
        MVENDORID = 3'd4,
        MARCHID   = 3'd5,
        MINSTRET  = 3'd6,
        MINSTRETH = 3'd7
    } csr_name_e;

endpackage

module ysyx_24080006_commit
    import ysyx_24080006_commit_pkg::*;
#(
    parameter int unsigned REDIRECT_TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid_i,
    output logic        wb_ready_o,
    input  logic [31:0] wb_pc_i,
    input  logic        wb_ecall_i,
    input  logic        wb_mret_i,
    input  csr_set_t    wb_csr_set_i,
    input  logic [11:0] wb_csr_addr_i,
    input  logic [31:0] wb_csr_wdata_i,
    input  logic        wb_rd_en_i,
    output csr_set_t    csr_set_o,
    output csr_name_e   csr_name_o,
    output logic [31:0] csr_wdata_o,
    output logic [31:0] csr_pc_o,
    output logic        csr_ecall_o,
    output logic        csr_mret_o,
    output logic        instret_o,
    input  logic [31:0] csr_rdata_i,
    output logic        rd_wen_o,
    output logic [31:0] rd_wdata_o,
    output logic        csr_illegal_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        redirect_err_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    state_e      state;
    logic [31:0] timer;
    logic        accept;
    logic        do_ecall;
    logic        do_mret;
    logic        do_csr;
    csr_name_e   addr_name;
    logic        addr_mapped;

    assign wb_ready_o = (state == IDLE);
    assign accept     = wb_valid_i & wb_ready_o;

    // ecall wins over mret, which wins over a CSR operation
    assign do_ecall = accept & wb_ecall_i;
    assign do_mret  = accept & ~wb_ecall_i & wb_mret_i;
    assign do_csr   = accept & ~wb_ecall_i & ~wb_mret_i & wb_csr_set_i.csr_enable;

    // Decode the 12-bit CSR address into the CSR file's name space
    always_comb begin
        addr_name   = MSTATUS;
        addr_mapped = 1'b1;
        case (wb_csr_addr_i)
            12'h300: addr_name = MSTATUS;
            12'h305: addr_name = MTVEC;
            12'h341: addr_name = MEPC;
            12'h342: addr_name = MCAUSE;
            12'hF11: addr_name = MVENDORID;
            12'hF12: addr_name = MARCHID;
            12'hB02: addr_name = MINSTRET;
            12'hB82: addr_name = MINSTRETH;
            default: addr_mapped = 1'b0;
        endcase
    end

    // CSR-side outputs are live only in the accept cycle; everything idles otherwise
    always_comb begin
        csr_set_o     = '0;
        csr_name_o    = MSTATUS;
        csr_wdata_o   = '0;
        csr_pc_o      = wb_pc_i;
        csr_ecall_o   = 1'b0;
        csr_mret_o    = 1'b0;
        instret_o     = 1'b0;
        rd_wen_o      = 1'b0;
        rd_wdata_o    = '0;
        csr_illegal_o = 1'b0;
        if (do_ecall) begin
            csr_ecall_o = 1'b1;
            csr_name_o  = MTVEC;
        end else if (do_mret) begin
            csr_mret_o = 1'b1;
            csr_name_o = MEPC;
            instret_o  = 1'b1;
        end else if (do_csr) begin
            instret_o = 1'b1;
            if (addr_mapped) begin
                csr_set_o   = wb_csr_set_i;
                csr_name_o  = addr_name;
                csr_wdata_o = wb_csr_wdata_i;
                rd_wen_o    = wb_rd_en_i;
                rd_wdata_o  = csr_rdata_i;
            end else begin
                csr_illegal_o = 1'b1;
            end
        end else if (accept) begin
            instret_o = 1'b1;
        end
    end

    // Flush while a trap is being taken and for as long as its redirect is pending
    assign flush_o = do_ecall | do_mret | (state == REDIRECT);

    // Redirect sequencer: captures the trap target and holds it until the fetch unit takes it
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            redirect_err_o   <= 1'b0;
            timer            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (do_ecall) begin
                        state            <= REDIRECT;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= {csr_rdata_i[31:2], 2'b00};
                    end else if (do_mret) begin
                        state            <= REDIRECT;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= csr_rdata_i;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        state            <= IDLE;
                        redirect_valid_o <= 1'b0;
                        timer            <= '0;
                    end else begin
                        if (timer != '1) begin
                            timer <= timer + 32'd1;
                        end
                        if ((REDIRECT_TIMEOUT != 0) && ((timer + 32'd1) >= REDIRECT_TIMEOUT)) begin
                            redirect_err_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    redirect_valid_o <= 1'b0;
                    timer            <= '0;
                end
            endcase
        end
    end

endmodule
